// File: rtl/dram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM: one access in flight,
// registered RAM controls, per-port grant / read-valid pulses and held read data.
module dram_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_gnt,
    output logic              e_rvalid,
    output logic [DATA_W-1:0] e_rdata,
    input  logic              e_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy
);

    // state  | meaning
    // IDLE   | sample requests, latch winner into mem_* registers
    // ISSUE  | RAM enable and winner's grant are high
    // DATA   | RAM read data returns, captured into winner's rdata
    // RESP   | arms winner's rvalid pulse for the following cycle
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DATA  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              last_e_q, last_e_d;
    logic              win_e_q, win_e_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_rden_q, mem_rden_d;
    logic              mem_wren_q, mem_wren_d;
    logic              p_gnt_q, p_gnt_d;
    logic              e_gnt_q, e_gnt_d;
    logic              p_rvalid_q, p_rvalid_d;
    logic              e_rvalid_q, e_rvalid_d;
    logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
    logic [DATA_W-1:0] e_rdata_q, e_rdata_d;

    logic elig_p, elig_e, any_elig, sel_e;

    // The lock removes the processor from arbitration; the pointer favours the port not last served.
    assign elig_p   = p_req & ~e_lock;
    assign elig_e   = e_req;
    assign any_elig = elig_p | elig_e;
    assign sel_e    = elig_e & (~elig_p | ~last_e_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_elig) state_d = S_ISSUE;
            S_ISSUE: state_d = mem_wren_q ? S_IDLE : S_DATA;
            S_DATA:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last_e_d   = last_e_q;
        win_e_d    = win_e_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_rden_d = 1'b0;
        mem_wren_d = 1'b0;
        p_gnt_d    = 1'b0;
        e_gnt_d    = 1'b0;
        p_rvalid_d = 1'b0;
        e_rvalid_d = 1'b0;
        p_rdata_d  = p_rdata_q;
        e_rdata_d  = e_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (any_elig) begin
                    last_e_d   = sel_e;
                    win_e_d    = sel_e;
                    mem_addr_d = sel_e ? e_addr  : p_addr;
                    mem_data_d = sel_e ? e_wdata : p_wdata;
                    mem_wren_d = sel_e ? e_we    : p_we;
                    mem_rden_d = sel_e ? ~e_we   : ~p_we;
                    e_gnt_d    = sel_e;
                    p_gnt_d    = ~sel_e;
                end
            end
            S_DATA: begin
                if (win_e_q) e_rdata_d = mem_q;
                else         p_rdata_d = mem_q;
            end
            S_RESP: begin
                e_rvalid_d = win_e_q;
                p_rvalid_d = ~win_e_q;
            end
            default: ;
        endcase
    end

    // Pointer resets to "external last" so the processor wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_e_q   <= 1'b1;
            win_e_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_rden_q <= 1'b0;
            mem_wren_q <= 1'b0;
            p_gnt_q    <= 1'b0;
            e_gnt_q    <= 1'b0;
            p_rvalid_q <= 1'b0;
            e_rvalid_q <= 1'b0;
            p_rdata_q  <= '0;
            e_rdata_q  <= '0;
        end else begin
            last_e_q   <= last_e_d;
            win_e_q    <= win_e_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_rden_q <= mem_rden_d;
            mem_wren_q <= mem_wren_d;
            p_gnt_q    <= p_gnt_d;
            e_gnt_q    <= e_gnt_d;
            p_rvalid_q <= p_rvalid_d;
            e_rvalid_q <= e_rvalid_d;
            p_rdata_q  <= p_rdata_d;
            e_rdata_q  <= e_rdata_d;
        end
    end

    assign p_gnt    = p_gnt_q;
    assign e_gnt    = e_gnt_q;
    assign p_rvalid = p_rvalid_q;
    assign e_rvalid = e_rvalid_q;
    assign p_rdata  = p_rdata_q;
    assign e_rdata  = e_rdata_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_rden = mem_rden_q;
    assign mem_wren = mem_wren_q;
    assign busy     = (state_q != S_IDLE);

endmodule
